// File: rtl/pb_event_ctrl_if.sv
// rtl/pb_event_ctrl_if.sv - Avalon-MM register port bundle for pb_event_ctrl
interface pb_event_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pb_event_ctrl.sv
// rtl/pb_event_ctrl.sv - push-button sync/debounce, sticky press capture and maskable irq
module pb_event_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    pb_event_ctrl_if.slave   avs,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [7:0]       r_evcount;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_press;
    logic [4:0]       w_pop;
    logic [8:0]       w_ev_sum;
    logic [31:0]      w_rdata;
    logic [WIDTH-1:0] w_wdata;
    logic             w_wr;
    logic             w_wr_ev;
    logic             w_wr_mask;
    logic             w_wr_edge;
    logic             w_unused;

    assign w_wr      = avs.chipselect & ~avs.write_n;
    assign w_wr_ev   = w_wr & (avs.address == 2'd1);
    assign w_wr_mask = w_wr & (avs.address == 2'd2);
    assign w_wr_edge = w_wr & (avs.address == 2'd3);
    assign w_wdata   = avs.writedata[WIDTH-1:0];
    assign w_unused  = &{1'b0, avs.writedata[31:WIDTH]};

    // Idle level of the buttons is 1, so the synchroniser powers up released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable   <= '1;
            r_stable_d <= '1;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            r_stable_d <= r_stable;
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_press = r_stable_d & ~r_stable;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) w_pop = w_pop + 5'(w_press[i]);
    end

    assign w_ev_sum = {1'b0, r_evcount} + 9'(w_pop);

    always_comb begin
        w_rdata = '0;
        case (avs.address)
            2'd0: w_rdata[WIDTH-1:0] = ~r_stable;
            2'd1: w_rdata[7:0]       = r_evcount;
            2'd2: w_rdata[WIDTH-1:0] = r_mask;
            2'd3: w_rdata[WIDTH-1:0] = r_edge;
            default: w_rdata = '0;
        endcase
    end

    // A press in the same cycle as a clear of that bit keeps the bit set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge     <= '0;
            r_mask     <= '0;
            r_evcount  <= '0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (w_wr_edge) r_edge <= (r_edge & ~w_wdata) | w_press;
            else           r_edge <= r_edge | w_press;
            if (w_wr_mask) r_mask <= w_wdata;
            if (w_wr_ev)                r_evcount <= 8'(w_pop);
            else if (w_ev_sum > 9'd255) r_evcount <= 8'hFF;
            else                        r_evcount <= w_ev_sum[7:0];
            r_irq      <= |(r_edge & r_mask);
            r_readdata <= w_rdata;
        end
    end

    assign avs.readdata = r_readdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_pb_event_ctrl.sv
// tb/tb_pb_event_ctrl.sv - randomized scoreboard bench for pb_event_ctrl
module tb_pb_event_ctrl;
    localparam int W = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] in_port = '1;
    logic         irq;

    pb_event_ctrl_if bus ();

    pb_event_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (bus.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a level is accepted once D consecutive synchronised
    // samples disagree with the accepted level; samples reach the debouncer 2 cycles late.
    logic [W-1:0] m_hist [0:D];
    logic [W-1:0] m_stable, m_pend, m_ec, m_mask;
    logic [7:0]   m_ev;
    logic         m_irq, m_rd;
    logic [31:0]  exp_q [$];

    function automatic logic [W-1:0] next_stable();
        logic [W-1:0] r;
        r = m_stable;
        for (int b = 0; b < W; b++) begin
            bit all_diff = 1'b1;
            for (int k = 1; k <= D; k++)
                if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) r[b] = ~m_stable[b];
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input int b);
        int s;
        s = int'(a) + b;
        return (s > 255) ? 8'd255 : 8'(s);
    endfunction

    function automatic logic [31:0] reg_value(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[W-1:0] = ~m_stable;
            2'd1: r[7:0]   = m_ev;
            2'd2: r[W-1:0] = m_mask;
            default: r[W-1:0] = m_ec;
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= D; k++) m_hist[k] <= '1;
            m_stable <= '1;
            m_pend   <= '0;
            m_ec     <= '0;
            m_mask   <= '0;
            m_ev     <= '0;
            m_irq    <= 1'b0;
            m_rd     <= 1'b0;
            exp_q.delete();
        end else begin
            m_hist[0] <= in_port;
            for (int k = 1; k <= D; k++) m_hist[k] <= m_hist[k-1];
            m_stable <= next_stable();
            m_pend   <= m_stable & ~next_stable();
            if (bus.chipselect && !bus.write_n && bus.address == 2'd3)
                m_ec <= (m_ec & ~bus.writedata[W-1:0]) | m_pend;
            else
                m_ec <= m_ec | m_pend;
            if (bus.chipselect && !bus.write_n && bus.address == 2'd1)
                m_ev <= 8'($countones(m_pend));
            else
                m_ev <= sat_add(m_ev, $countones(m_pend));
            if (bus.chipselect && !bus.write_n && bus.address == 2'd2)
                m_mask <= bus.writedata[W-1:0];
            m_irq <= |(m_ec & m_mask);
            m_rd  <= bus.chipselect && bus.write_n;
            if (bus.chipselect && bus.write_n)
                exp_q.push_back(reg_value(bus.address));
        end
    end

    // Monitor: one popped expectation per issued read, irq every cycle
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (m_rd) begin
                    if (exp_q.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
                    else chk($sformatf("readdata_a%0d", dut.avs.address), bus.readdata, exp_q.pop_front());
                end
                chk("irq", {31'd0, irq}, {31'd0, m_irq});
            end
        end
    end

    task automatic idle();
        bus.address    = 2'($urandom_range(0, 3));
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.writedata  = $urandom;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle();
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        tick(1);
    endtask

    task automatic rd(input logic [1:0] a);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(negedge clk);
        idle();
    endtask

    initial begin
        int lat;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) rd(2'(a));
        tick(4);

        in_port[2] = 1'b0;
        tick(20);
        in_port[2] = 1'b1;
        tick(20);

        wr(2'd2, 32'h4);
        in_port[2] = 1'b0;
        tick(20);
        wr(2'd3, 32'h4);
        tick(5);
        in_port[2] = 1'b1;
        tick(20);

        // Glitches just below and exactly at the debounce length
        in_port[0] = 1'b0; tick(5);     in_port[0] = 1'b1; tick(20);
        in_port[0] = 1'b0; tick(D - 1); in_port[0] = 1'b1; tick(20);
        in_port[0] = 1'b0; tick(D);     in_port[0] = 1'b1; tick(20);
        wr(2'd3, 32'hF);
        tick(3);

        in_port[1] = 1'b0;
        lat = 0;
        while (!m_pend[1] && lat < 40) begin
            tick(1);
            lat++;
        end
        chk("press_wait_timeout", {31'd0, m_pend[1]}, 32'd1);
        wr(2'd3, 32'h2);
        rd(2'd3);
        rd(2'd3);
        in_port[1] = 1'b1;
        tick(20);

        wr(2'd2, 32'hF);
        for (int n = 0; n < 80; n++) begin
            in_port = '0; tick(12);
            in_port = '1; tick(12);
            if (n % 7 == 0) wr(2'd3, 32'($urandom_range(0, 15)));
        end
        rd(2'd1);
        wr(2'd1, 32'h0);
        rd(2'd1);

        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 4))
                0, 1, 2: begin
                    in_port[$urandom_range(0, W-1)] ^= 1'b1;
                    tick($urandom_range(1, 14));
                end
                3: wr(2'($urandom_range(1, 3)), $urandom);
                default: tick($urandom_range(1, 4));
            endcase
        end
        in_port = '1;
        tick(20);

        // Reset while bit 3 is mid-debounce, button kept held
        wr(2'd1, 32'h0);
        in_port[3] = 1'b0;
        tick(7);
        #1 reset_n = 1'b0;
        bus.chipselect = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus.address    = 2'd0;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        lat = 0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.readdata == 32'h8) lat = i;
        end
        chk("reset_press_latency", 32'(lat), 32'(D + 3));
        tick(5);
        rd(2'd1);
        rd(2'd3);
        in_port = '1;
        tick(20);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pb_event_ctrl.md
Name: pb_event_ctrl

Overview:
- Avalon-MM slave controller for the active-low push-button inputs.
- Synchronises and debounces each button, then captures press events in a sticky edge register.
- Raises a maskable interrupt so software stops polling the raw button PIO.
- Sits between the board buttons and the Qsys interconnect; its register map is PIO-compatible.

Parameters:
WIDTH, 4, number of button inputs (1..16)
DEBOUNCE_CYCLES, 500000, stable-input cycles required before accepting a level (10 ms at 50 MHz); minimum 2
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset; released synchronously by the system
address  in  2  Avalon register select
chipselect  in  1  Avalon chip select
write_n  in  1  Avalon write strobe, active low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
in_port  in  WIDTH  raw button levels; 0 = pressed
irq  out  1  level interrupt, active high

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (reset_n); all flops clear immediately on assertion.
- Reset values:
  - sync stages and stable = all 1s (released)
  - debounce counters = 0
  - edgecapture = 0, irqmask = 0, evcount = 0
  - readdata = 0, irq = 0
- Synchroniser: 2-FF per bit on in_port, producing sync.
- Debounce, per bit, independent counters:
  - sync == stable: counter <= 0.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - Otherwise: counter <= counter + 1.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - Latency from an in_port change to a stable change = 2 + DEBOUNCE_CYCLES cycles.
- Press event: stable bit goes 1->0 (registered stable_d vs stable). Releases (0->1) generate no event.
- Register map (write when chipselect=1 and write_n=0):
  - 0 DATA: read ~stable, so 1 = pressed, zero-extended. Writes ignored.
  - 1 EVCOUNT: read 8-bit count of press events, zero-extended. Saturates at 255, no wrap. Any write clears it to 0.
  - 2 IRQMASK: WIDTH bits, read/write.
  - 3 EDGECAPTURE: WIDTH bits, sticky. Write-1-to-clear per bit; bits written as 0 are unchanged.
- Simultaneous events:
  - A press and a clear on the same bit in the same cycle: the press wins, bit stays 1.
  - Presses on several bits in the same cycle add the popcount to EVCOUNT, saturating.
  - An EVCOUNT clear coinciding with presses loads the popcount of those presses.
- Read:
  - readdata <= selected register every cycle, regardless of chipselect, so read latency = 1.
  - Unused upper bits are always 0.
  - Reads have no side effects.
- irq <= |(edgecapture & irqmask), registered.
  - irq asserts 1 cycle after edgecapture/mask become nonzero.
  - irq deasserts 1 cycle after the clearing write takes effect.
- Reset mid-debounce discards the pending count. After reset release, a held button needs a full DEBOUNCE_CYCLES again and then generates a press event.

Test Plan:
(Run with DEBOUNCE_CYCLES=8.)
- Reset, all inputs released; read addr 0..3 -> all return 0, irq=0.
- Drive in_port[2]=0 and hold -> DATA reads 0x4 starting 2+8 cycles later (plus 1 for the readdata register). EDGECAPTURE=0x4, EVCOUNT=1, irq stays 0 (mask 0).
- Write IRQMASK=0x4, then press bit 2 again -> irq=1 one cycle after EDGECAPTURE bit sets. Write EDGECAPTURE=0x4 -> irq=0 one cycle later.
- Pulse in_port[0] low for 5 cycles -> DATA, EDGECAPTURE and EVCOUNT unchanged.
- Drive a new press on bit 1 while writing EDGECAPTURE=0x2 in the detect cycle -> bit 1 remains set. Repeat 300 presses -> EVCOUNT reads 255, then write addr 1 -> reads 0.
- Assert reset_n mid-debounce (counter=5) with the button held; release reset -> press detected exactly 2+8 cycles after release, EVCOUNT=1.
